// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement operation is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    r_r;
  logic [W-1:0]    q_r;
  logic [W-1:0]    d_r;
  logic [CW-1:0]   cnt_r;
  logic [W:0]      t_s;
  logic [W+1:0]    sub_s;
  logic [W-1:0]    r_step_s;
  logic [W-1:0]    q_step_s;
  logic [W-1:0]    a_mag_s;
  logic [W-1:0]    b_mag_s;
  logic [W-1:0]    q_fin_s;
  logic [W-1:0]    r_fin_s;
  logic            zero_div_s;

`ifdef SEQ_DIV_SIGNED_EN
  logic            neg_q_r;
  logic            neg_r_r;

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction
`endif

  assign zero_div_s = (divisor == {W{1'b0}});

  // Operand magnitudes captured on acceptance and sign fix-up of the final step
  always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
    a_mag_s = dividend[W-1] ? negate(dividend) : dividend;
    b_mag_s = divisor[W-1]  ? negate(divisor)  : divisor;
    q_fin_s = neg_q_r ? negate(q_step_s) : q_step_s;
    r_fin_s = neg_r_r ? negate(r_step_s) : r_step_s;
`else
    a_mag_s = dividend;
    b_mag_s = divisor;
    q_fin_s = q_step_s;
    r_fin_s = r_step_s;
`endif
  end

  // One restoring step; the extra top bit of T keeps divisors with MSB set correct
  always_comb begin
    t_s   = {r_r, q_r[W-1]};
    sub_s = {1'b0, t_s} - {2'b00, d_r};
    if (!sub_s[W+1]) begin
      r_step_s = sub_s[W-1:0];
      q_step_s = {q_r[W-2:0], 1'b1};
    end else begin
      r_step_s = t_s[W-1:0];
      q_step_s = {q_r[W-2:0], 1'b0};
    end
  end

  // Controller next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (zero_div_s) state_s = DONE;
          else            state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(1)) state_s = DONE;
        else                 state_s = CALC;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result write on entry to DONE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_r         <= {W{1'b0}};
      q_r         <= {W{1'b0}};
      d_r         <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient    <= {W{1'b0}};
      remainder   <= {W{1'b0}};
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (zero_div_s) begin
              quotient    <= {W{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              d_r         <= b_mag_s;
              q_r         <= a_mag_s;
              r_r         <= {W{1'b0}};
              cnt_r       <= CW'(W);
              div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
              neg_q_r     <= dividend[W-1] ^ divisor[W-1];
              neg_r_r     <= dividend[W-1];
`endif
            end
          end
        end
        CALC: begin
          r_r   <= r_step_s;
          q_r   <= q_step_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            quotient  <= q_fin_s;
            remainder <= r_fin_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed vector table, multi-cycle corner sequences,
// and randomized divides checked against a plain-arithmetic reference model.
module tb_seq_div;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  seq_div #(.W(W)) dut (
    .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: {dz, q, r} from ordinary integer division
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
`ifdef SEQ_DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[7:0], r[7:0]};
  endfunction

  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz);
    logic [7:0] prev_q;
    logic [7:0] prev_r;
    int lat;
    int elat;
    bit held;
    elat = (b == 8'd0) ? 1 : W + 1;
    @(negedge clk);
    prev_q = quotient;
    prev_r = remainder;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    lat = -1;
    held = 1'b1;
    for (int j = 1; j <= W + 4; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (quotient !== prev_q || remainder !== prev_r || busy !== 1'b1) held = 1'b0;
      @(negedge clk);
    end
    check({name, " latency"}, lat, elat);
    check({name, " hold_busy"}, int'(held), 1);
    check({name, " quotient"}, int'(quotient), int'(eq));
    check({name, " remainder"}, int'(remainder), int'(er));
    check({name, " div_by_zero"}, int'(div_by_zero), int'(edz));
    check({name, " busy_in_done"}, int'(busy), 1);
    @(negedge clk);
    check({name, " done_one_cycle"}, int'({done, busy}), 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [16:0] m;
    logic [7:0] a;
    logic [7:0] b;
    int t_done[$];
    int cnt;
    bit quiet;

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{"neg100_7",  8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
    vecs.push_back('{"100_neg7",  8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0});
    vecs.push_back('{"neg128_neg1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{"42_0",      8'd42, 8'd0,  8'hFF, 8'd42, 1'b1});
    vecs.push_back('{"100_7",     8'd100, 8'd7, 8'd14, 8'd2,  1'b0});
`else
    vecs.push_back('{"100_7",     8'd100, 8'd7,   8'd14,  8'd2,   1'b0});
    vecs.push_back('{"255_128",   8'd255, 8'd128, 8'd1,   8'd127, 1'b0});
    vecs.push_back('{"5_9",       8'd5,   8'd9,   8'd0,   8'd5,   1'b0});
    vecs.push_back('{"42_0",      8'd42,  8'd0,   8'd255, 8'd42,  1'b1});
    vecs.push_back('{"100_7_clr_dz", 8'd100, 8'd7, 8'd14, 8'd2,  1'b0});
    vecs.push_back('{"200_3",     8'd200, 8'd3,   8'd66,  8'd2,   1'b0});
`endif

    clr = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, done, div_by_zero, quotient, remainder}), 0);
    clr = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({busy, done}), 0);

    foreach (vecs[i]) run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // Reset during the 3rd CALC cycle aborts with no done pulse
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    check("midcalc_clr_outputs", int'({busy, done, div_by_zero, quotient, remainder}), 0);
    @(negedge clk);
    clr = 1'b0;
    quiet = 1'b1;
    for (int j = 0; j < W + 4; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("midcalc_clr_no_done", int'(quiet), 1);
    m = model(8'd100, 8'd7);
    run_div("after_clr_100_7", 8'd100, 8'd7, m[15:8], m[7:0], m[16]);

    // start held high: back-to-back results every W+2 cycles
    m = model(8'd200, 8'd3);
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    cnt = 0;
    while (t_done.size() < 3 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (done) begin
        t_done.push_back(cnt);
        check("b2b_quotient", int'(quotient), int'(m[15:8]));
        check("b2b_remainder", int'(remainder), int'(m[7:0]));
      end
    end
    start = 1'b0;
    check("b2b_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      check("b2b_first_latency", t_done[0], W + 1);
      check("b2b_period_1", t_done[1] - t_done[0], W + 2);
      check("b2b_period_2", t_done[2] - t_done[1], W + 2);
    end
    repeat (3) @(negedge clk);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'hFF; end
      if (i == 1) begin a = 8'hFF; b = 8'h01; end
      m = model(a, b);
      run_div($sformatf("rand%0d_%0h_%0h", i, a, b), a, b, m[15:8], m[7:0], m[16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
